booth_mult_seq: RTL and testbench

//  Sequential signed 32x32 -> 64-bit multiplier for the ALU multiply path; radix-2 Booth, one iteration per clk.

---
 rtl/booth_mult_seq_pkg.sv | 34 +++
 rtl/adder.sv | 54 +++++
 rtl/booth_mult_seq.sv | 94 +++++++++
 tb/tb_booth_mult_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_seq_pkg.sv
// rtl/booth_mult_seq_pkg.sv - shared widths, FSM encodings and Booth operand select for booth_mult_seq
package booth_mult_seq_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH:0] op;
        logic           cin;
    } booth_op_t;

    // Pair {Q[0],q_1}: 01 adds M, 10 adds ~M with carry-in (i.e. subtracts M), else adds zero.
    function automatic booth_op_t booth_select(input logic [1:0] pair, input logic [WIDTH:0] m);
        booth_op_t r;
        r.op  = '0;
        r.cin = 1'b0;
        case (pair)
            2'b01: r.op = m;
            2'b10: begin
                r.op  = ~m;
                r.cin = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 32-bit carry-lookahead adder built from 4-bit lookahead groups
module adder
    import booth_mult_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] s,
    output logic             c32
);

    localparam int GRP = 4;
    localparam int NG  = WIDTH / GRP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = c0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[GRP*j+3]
                  | (p[GRP*j+3] & g[GRP*j+2])
                  | (p[GRP*j+3] & p[GRP*j+2] & g[GRP*j+1])
                  | (p[GRP*j+3] & p[GRP*j+2] & p[GRP*j+1] & g[GRP*j]);
            gp[j] = &p[GRP*j +: GRP];
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        // Carries inside each group are expanded from the group carry-in, not rippled.
        for (int j = 0; j < NG; j++) begin
            c[GRP*j]   = gc[j];
            c[GRP*j+1] = g[GRP*j] | (p[GRP*j] & gc[j]);
            c[GRP*j+2] = g[GRP*j+1]
                       | (p[GRP*j+1] & g[GRP*j])
                       | (p[GRP*j+1] & p[GRP*j] & gc[j]);
            c[GRP*j+3] = g[GRP*j+2]
                       | (p[GRP*j+2] & g[GRP*j+1])
                       | (p[GRP*j+2] & p[GRP*j+1] & g[GRP*j])
                       | (p[GRP*j+2] & p[GRP*j+1] & p[GRP*j] & gc[j]);
        end
        s   = p ^ c;
        c32 = gc[NG];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential signed radix-2 Booth multiplier, one iteration per clock through the CLA
module booth_mult_seq
    import booth_mult_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    logic [WIDTH:0]     m33;
    logic [WIDTH:0]     a33;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [CNT_W-1:0]   count;

    booth_op_t          sel;
    logic [WIDTH-1:0]   sum_lo;
    logic               c_out;
    logic [WIDTH:0]     sum33;
    logic [WIDTH:0]     a33_next;
    logic [WIDTH-1:0]   q_next;

    always_comb sel = booth_select({q[0], q_1}, m33);

    adder u_adder (
        .a   (a33[WIDTH-1:0]),
        .b   (sel.op[WIDTH-1:0]),
        .c0  (sel.cin),
        .s   (sum_lo),
        .c32 (c_out)
    );

    // Bit 32 is the sign extension of the 33-bit sum so -M of M=-2^31 stays representable.
    assign sum33    = {a33[WIDTH] ^ sel.op[WIDTH] ^ c_out, sum_lo};
    assign a33_next = {sum33[WIDTH], sum33[WIDTH:1]};
    assign q_next   = {sum33[0], q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m33     <= '0;
            a33     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m33   <= {mcand[WIDTH-1], mcand};
                        a33   <= '0;
                        q     <= mplier;
                        q_1   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a33   <= a33_next;
                    q     <= q_next;
                    q_1   <= q[0];
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        product <= {a33_next[WIDTH-1:0], q_next};
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - scoreboard bench for booth_mult_seq against a $signed product model
module tb_booth_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int total;
    int bad;
    int done_cnt;
    int cyc;
    logic prev_done;
    logic [63:0] sb[$];

    booth_mult_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q);
        longint r;
        r = longint'($signed(m)) * longint'($signed(q));
        return r;
    endfunction

    // Scoreboard side: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                check_eq("done_single", {63'd0, prev_done}, 64'd0);
                if (sb.size() == 0)
                    check_eq("sb_underflow", 64'd1, 64'd0);
                else
                    check_eq("product", product, sb.pop_front());
                done_cnt <= done_cnt + 1;
            end
        end
        prev_done <= done;
    end

    task automatic apply_start(input logic [31:0] m, input logic [31:0] q, input bit hold);
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        sb.push_back(model(m, q));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq(tag, {63'd0, done}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int first_done;
        int busy_n;
        int d0;
        int prev_acc;
        logic [31:0] rm;
        logic [31:0] rq;

        total = 0; bad = 0; done_cnt = 0; cyc = 0; prev_done = 1'b0;
        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_product", product, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 7 x -3 with latency and busy-width measurement
        apply_start(32'd7, 32'hFFFF_FFFD, 1'b0);
        k = 0; first_done = -1; busy_n = 0;
        while (k < 60) begin
            if (done && first_done < 0) first_done = k;
            if (busy) busy_n++;
            else break;
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("t1_latency", 64'(first_done), 64'd32);
        check_eq("t1_busy_cycles", 64'(busy_n), 64'd33);
        check_eq("t1_product", product, 64'hFFFF_FFFF_FFFF_FFEB);

        apply_start(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done("t2_done");
        check_eq("t2_product", product, 64'h4000_0000_0000_0000);
        @(posedge clk); #1;

        apply_start(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        wait_done("t3a_done");
        check_eq("t3a_product", product, 64'h3FFF_FFFF_0000_0001);
        @(posedge clk); #1;
        apply_start(32'h8000_0000, 32'd1, 1'b0);
        wait_done("t3b_done");
        check_eq("t3b_product", product, 64'hFFFF_FFFF_8000_0000);
        @(posedge clk); #1;

        // start during RUN and operand churn must be ignored
        d0 = done_cnt;
        apply_start(32'd5, 32'd6, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        mcand = 32'd9; mplier = $urandom; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mcand = $urandom; mplier = $urandom;
        wait_done("t4_done");
        check_eq("t4_product", product, 64'd30);
        repeat (40) @(posedge clk);
        #1;
        check_eq("t4_done_count", 64'(done_cnt - d0), 64'd1);
        check_eq("t4_product_hold", product, 64'd30);

        // reset mid-RUN discards the operation
        apply_start(32'd1234, 32'd77, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_busy", {63'd0, busy}, 64'd0);
        check_eq("t5_done", {63'd0, done}, 64'd0);
        check_eq("t5_product", product, 64'd0);
        sb.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        apply_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("t5b_done");
        check_eq("t5b_product", product, 64'd1);
        @(posedge clk); #1;

        // start held high: one accept every 34 cycles
        d0 = done_cnt;
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            rm = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
            rq = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
            mcand = rm; mplier = rq; start = 1'b1;
            sb.push_back(model(rm, rq));
            k = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
            end while (!busy && k < 40);
            if (i > 0) check_eq("t6_period", 64'(cyc - prev_acc), 64'd34);
            prev_acc = cyc;
            wait_done("t6_done");
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_done_count", 64'(done_cnt - d0), 64'd1000);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
